// File: rtl/sradd_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sradd_seq: multi-cycle handshaked FP32 adder, truncating, flush-to-zero.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module sradd_seq #(
  parameter int ALIGN_LIMIT = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] z,
  output logic        busy
);

  localparam logic [31:0] LIMIT = 32'(ALIGN_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ADD   = 3'd2,
    S_NORM  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state_q;
  logic        sign_q;
  logic        sub_q;
  logic [8:0]  exp_q;
  logic [24:0] ml_q;
  logic [24:0] ms_q;
  logic [7:0]  cnt_q;
  logic [31:0] z_q;
  logic        out_valid_q;
  logic        busy_q;

  logic        a_big;
  logic [31:0] l_op;
  logic [31:0] s_op;
  logic [7:0]  ediff;
  logic        far;
  logic [8:0]  exp_inc;
  logic [8:0]  exp_dec;

  // Magnitude order is exponent then mantissa, i.e. the unsigned 31-bit field.
  assign a_big   = (a[30:0] >= b[30:0]);
  assign l_op    = a_big ? a : b;
  assign s_op    = a_big ? b : a;
  assign ediff   = l_op[30:23] - s_op[30:23];
  assign far     = ({24'd0, ediff} >= LIMIT);
  assign exp_inc = exp_q + 9'd1;
  assign exp_dec = exp_q - 9'd1;

  assign in_ready  = rst_n && (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign z         = z_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sign_q      <= 1'b0;
      sub_q       <= 1'b0;
      exp_q       <= 9'd0;
      ml_q        <= 25'd0;
      ms_q        <= 25'd0;
      cnt_q       <= 8'd0;
      z_q         <= 32'd0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            busy_q <= 1'b1;
            if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
              z_q         <= 32'hFFFF_FFFF;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else if (a[30:23] == 8'd0 && b[30:23] == 8'd0) begin
              z_q         <= 32'd0;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else if (a[30:23] == 8'd0) begin
              z_q         <= b;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else if (b[30:23] == 8'd0) begin
              z_q         <= a;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else if (far) begin
              z_q         <= l_op;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              sign_q  <= l_op[31];
              sub_q   <= l_op[31] ^ s_op[31];
              exp_q   <= {1'b0, l_op[30:23]};
              ml_q    <= {2'b01, l_op[22:0]};
              ms_q    <= {2'b01, s_op[22:0]};
              cnt_q   <= ediff;
              state_q <= S_ALIGN;
            end
          end
        end
        S_ALIGN: begin
          if (cnt_q == 8'd0) begin
            state_q <= S_ADD;
          end else begin
            ms_q  <= ms_q >> 1;
            cnt_q <= cnt_q - 8'd1;
          end
        end
        S_ADD: begin
          ml_q    <= sub_q ? (ml_q - ms_q) : (ml_q + ms_q);
          state_q <= S_NORM;
        end
        S_NORM: begin
          // Exact cancellation is caught on the first normalisation cycle.
          if (ml_q == 25'd0) begin
            z_q         <= 32'd0;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else if (ml_q[24]) begin
            ml_q        <= ml_q >> 1;
            exp_q       <= exp_inc;
            z_q         <= (exp_inc == 9'd255) ? 32'hFFFF_FFFF
                                               : {sign_q, exp_inc[7:0], ml_q[23:1]};
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else if (ml_q[23]) begin
            z_q         <= {sign_q, exp_q[7:0], ml_q[22:0]};
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            ml_q  <= ml_q << 1;
            exp_q <= exp_dec;
            if (exp_dec == 9'd0) begin
              z_q         <= 32'd0;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sradd_seq.sv
`default_nettype none
// Directed, table-driven bench for sradd_seq: values, latency and control.
module tb_sradd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] z;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sradd_seq #(.ALIGN_LIMIT(24)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .busy      (busy)
  );

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] vz;
    int          lat;   // 0 = latency not checked
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one operation; returns the cycle (edge index after accept) where out_valid is seen.
  task automatic issue(input logic [31:0] va, input logic [31:0] vb, input logic ordy,
                       input string nm, output int cyc, output logic ctl_ok);
    logic got;
    @(negedge clk);
    chk({nm, " in_ready_before"}, {31'd0, in_ready}, 32'd1);
    a = va; b = vb; in_valid = 1'b1; out_ready = ordy;
    @(posedge clk);
    #1 in_valid = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    cyc = 0; got = 1'b0; ctl_ok = 1'b1;
    while (cyc < 200 && !got) begin
      @(negedge clk);
      cyc++;
      if (busy !== 1'b1 || in_ready !== 1'b0) ctl_ok = 1'b0;
      if (out_valid === 1'b1) got = 1'b1;
    end
    chk({nm, " out_valid_timeout"}, {31'd0, got}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int   cyc;
    logic ok;
    issue(v.va, v.vb, 1'b1, nm, cyc, ok);
    chk({nm, " z"}, z, v.vz);
    chk({nm, " busy_ready_during_op"}, {31'd0, ok}, 32'd1);
    if (v.lat != 0) chk({nm, " latency"}, 32'(cyc), 32'(v.lat));
    @(posedge clk);
    #1;
    chk({nm, " idle_after_handshake"}, {29'd0, out_valid, busy, in_ready}, 32'b001);
  endtask

  initial begin
    int   cyc;
    logic ok;
    logic stable;

    vecs[0]  = '{32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 4};
    vecs[1]  = '{32'h3F80_0000, 32'hBF40_0000, 32'h3E80_0000, 7};
    vecs[2]  = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 4};
    vecs[3]  = '{32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, 1};
    vecs[4]  = '{32'h0000_0000, 32'hC000_0000, 32'hC000_0000, 1};
    vecs[5]  = '{32'h7F80_0000, 32'h3F80_0000, 32'hFFFF_FFFF, 1};
    vecs[6]  = '{32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'hFFFF_FFFF, 4};
    vecs[7]  = '{32'h4000_0000, 32'h3F80_0000, 32'h4040_0000, 5};
    vecs[8]  = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 5};
    vecs[9]  = '{32'h0000_0001, 32'h0040_0000, 32'h0000_0000, 1};
    vecs[10] = '{32'h3F80_0000, 32'h8000_0000, 32'h3F80_0000, 1};
    vecs[11] = '{32'h3F80_0000, 32'h3400_0000, 32'h3F80_0001, 27};
    vecs[12] = '{32'hBF80_0000, 32'hBF80_0000, 32'hC000_0000, 4};
    vecs[13] = '{32'h0080_0000, 32'h8080_0001, 32'h0000_0000, 0};

    // Reset state
    #12;
    chk("reset outputs", {z[31:0]}, 32'd0);
    chk("reset ctl", {29'd0, out_valid, busy, in_ready}, 32'b000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready after reset release", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: result held for 10 cycles
    issue(32'h3F80_0000, 32'h3F80_0000, 1'b0, "bp", cyc, ok);
    chk("bp latency", 32'(cyc), 32'd4);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (z !== 32'h4000_0000 || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1)
        stable = 1'b0;
    end
    chk("bp hold stable", {31'd0, stable}, 32'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp release idle", {29'd0, out_valid, busy, in_ready}, 32'b001);

    // Reset in the middle of a long ALIGN
    @(negedge clk);
    a = 32'h3F80_0000; b = 32'h3400_0000; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid align busy", {30'd0, busy, out_valid}, 32'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset ctl", {29'd0, out_valid, busy, in_ready}, 32'b000);
    chk("async reset z", z, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready after mid reset", {31'd0, in_ready}, 32'd1);

    run_vec(vecs[0], "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
